fetch_unit: RTL and testbench

Instruction fetch front end that sits directly upstream of the single-cycle core's decode/execute path. It replaces the preloaded combinational instruction ROM with a request/acknowledge memory bus that may insert wait states. Fetched words go into a small prefetch FIFO, which the consumer drains through a valid/ready handshake. A redirect input flushes the FIFO and restarts fetch at a new PC, for use by branches and jumps.

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues word fetches on a request/acknowledge
// memory bus and tolerates any number of wait states. Returned words are kept
// in a small prefetch FIFO, and the consumer drains that FIFO through a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch at a
// new PC. A response that is still in flight when the redirect arrives is
// discarded.
//
// Parameters
//   RESET_PC     fetch address loaded on reset
//   DEPTH        prefetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   mem_req      fetch request; held with mem_addr stable until mem_ack
//   mem_addr     word-aligned fetch address
//   mem_ack      response valid this cycle
//   mem_rdata    instruction word, valid with mem_ack
//   inst_valid   FIFO head holds an instruction
//   inst_ready   consumer takes the head when inst_valid & inst_ready
//   inst         instruction at the FIFO head
//   inst_pc      address of the FIFO head instruction
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch PC; bits [1:0] are ignored
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;

    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [AW+1:0] count_after;

    logic          push;
    logic          pop;
    logic          flush;

    // Outputs come straight from registered state or the FIFO head mux, so
    // neither mem_ack nor inst_ready reaches mem_req combinationally.
    assign mem_req    = (state != IDLE);
    assign mem_addr   = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = fifo_inst[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];

    assign flush = redirect;
    assign push  = (state == REQ) && mem_ack && !redirect;
    assign pop   = inst_valid && inst_ready && !redirect;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        count_after  = {1'b0, count}
                     + {{(AW+1){1'b0}}, push}
                     - {{(AW+1){1'b0}}, pop};
        count_nxt    = flush ? '0 : count_after[AW:0];

        if (redirect) begin
            fetch_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
        end

        unique case (state)
            IDLE: begin
                if (!redirect && (count < FULL)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // A redirect without ack leaves the old request pending on
                // the bus; its response must be swallowed in DISCARD.
                if (redirect) begin
                    state_nxt = mem_ack ? IDLE : DISCARD;
                end else if (mem_ack && !(count_after < {1'b0, FULL})) begin
                    state_nxt = IDLE;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]   <= fetch_pc;
                    fifo_inst[wr_ptr] <= mem_rdata;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A memory responder latches the address on the first
// cycle of each request and answers after a programmable number of wait
// states with word = addr >> 2. A queue-based reference model predicts every
// output each cycle. Directed phases then pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    bit          m_busy;   // a request is on the bus
    bit          m_drop;   // the outstanding response belongs to a flushed stream

    task automatic model_step();
        bit pop;
        int after;
        if (reset) begin
            m_pc   = RESET_PC;
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_q.delete();
            return;
        end
        pop = (m_q.size() != 0) && inst_ready && !redirect;
        if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            if (m_busy) begin
                if (mem_ack) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
            return;
        end
        if (!m_busy) begin
            if (m_q.size() < DEPTH) m_busy = 1'b1;
        end else if (m_drop) begin
            if (mem_ack) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
        end else if (mem_ack) begin
            after = m_q.size() + 1 - (pop ? 1 : 0);
            m_q.push_back('{m_pc, mem_rdata});
            m_pc = m_pc + 32'd4;
            if (after >= DEPTH) m_busy = 1'b0;
        end
        if (pop) void'(m_q.pop_front());
    endtask

    task automatic compare();
        check_bit("mem_req", mem_req, m_busy);
        check("mem_addr", mem_addr, m_pc);
        check_bit("inst_valid", inst_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("inst", inst, m_q[0].word);
            check("inst_pc", inst_pc, m_q[0].pc);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          r_pend     = 1'b0;
    logic [31:0] r_addr     = '0;
    int          r_wait     = 0;
    int          wait_n     = 0;
    bit          rand_waits = 1'b0;
    bit          junk_ack   = 1'b0;

    task automatic drive_mem();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if (reset) begin
            r_pend = 1'b0;
            if (junk_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            return;
        end
        if (!r_pend && mem_req) begin
            r_pend = 1'b1;
            r_addr = mem_addr;
            r_wait = rand_waits ? int'($urandom_range(0, 3)) : wait_n;
        end
        if (r_pend) begin
            if (r_wait == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = r_addr >> 2;
                r_pend    = 1'b0;
            end else begin
                r_wait--;
            end
        end else if (junk_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    // ---------------- per-cycle driver ----------------
    logic [31:0] pop_pc[$];
    logic [31:0] pop_word[$];
    int          pop_cyc[$];
    int          n_acc = 0;

    task automatic clear_log();
        pop_pc.delete();
        pop_word.delete();
        pop_cyc.delete();
    endtask

    task automatic tick();
        drive_mem();
        compare();
        if (!reset && inst_valid && inst_ready && !redirect) begin
            pop_pc.push_back(inst_pc);
            pop_word.push_back(inst);
            pop_cyc.push_back(cyc);
        end
        if (!reset && mem_req && mem_ack && !redirect) n_acc++;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_pop(input int k, input logic [31:0] pc, input logic [31:0] word);
        if (pop_pc.size() > k) begin
            check("pop_pc", pop_pc[k], pc);
            check("pop_inst", pop_word[k], word);
        end else begin
            check_int("pop_missing", pop_pc.size(), k + 1);
        end
    endtask

    initial begin
        int lat;
        int guard;
        reset       = 1'b1;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        model_step();
        repeat (2) @(posedge clk);
        #1;
        repeat (2) tick();

        // Reset state, literal.
        check_bit("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check_bit("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);

        // Zero-wait stream.
        reset      = 1'b0;
        inst_ready = 1'b1;
        wait_n     = 0;
        clear_log();
        lat = 0;
        while (!inst_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_int("fill_latency", lat, 2);
        repeat (8) tick();
        for (int k = 0; k < 8; k++) check_pop(k, 32'(4 * k), 32'(k));
        for (int k = 1; k < 8 && k < pop_cyc.size(); k++)
            check_int("stream_gap", pop_cyc[k] - pop_cyc[k-1], 1);

        // Backpressure.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        inst_ready  = 1'b0;
        tick();
        redirect = 1'b0;
        n_acc    = 0;
        repeat (10) tick();
        check_int("bp_pushes", n_acc, DEPTH);
        check_bit("bp_mem_req", mem_req, 1'b0);
        check_bit("bp_valid", inst_valid, 1'b1);
        clear_log();
        inst_ready = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < 4; k++) check_pop(k, 32'h200 + 32'(4 * k), 32'h80 + 32'(k));

        // Three wait states: one instruction every four cycles.
        wait_n = 3;
        repeat (6) tick();
        clear_log();
        repeat (30) tick();
        for (int k = 1; k < 5; k++) begin
            if (pop_cyc.size() > k) check_int("wait3_gap", pop_cyc[k] - pop_cyc[k-1], 4);
            else check_int("wait3_pops", pop_cyc.size(), k + 1);
        end

        // Redirect to 0x103 while the request to 0x8 is pending.
        reset      = 1'b1;
        inst_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        guard = 0;
        while (!(inst_valid && !mem_req && guard > 2) && guard < 50) begin
            tick();
            guard++;
        end
        check_bit("full_reached", guard < 50, 1'b1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        guard = 0;
        while (!(mem_req && mem_addr == 32'h8) && guard < 10) begin
            tick();
            guard++;
        end
        check_bit("req8_seen", guard < 10, 1'b1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        check_bit("redir_valid", inst_valid, 1'b0);
        check_bit("redir_discard_req", mem_req, 1'b1);
        check("redir_addr", mem_addr, 32'h100);
        guard = 0;
        while (mem_req && guard < 20) begin
            tick();
            guard++;
        end
        while (!mem_req && guard < 20) begin
            tick();
            guard++;
        end
        check_bit("redir_req_timeout", guard < 20, 1'b1);
        check("redir_next_req", mem_addr, 32'h100);
        clear_log();
        guard = 0;
        while (pop_pc.size() == 0 && guard < 20) begin
            tick();
            guard++;
        end
        check_pop(0, 32'h100, 32'h40);

        // Redirect coincident with mem_ack and a would-be pop.
        wait_n = 0;
        repeat (6) tick();
        check_bit("coinc_pre_valid", inst_valid, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        tick();
        redirect = 1'b0;
        check_bit("coinc_valid", inst_valid, 1'b0);
        check_bit("coinc_req", mem_req, 1'b0);
        check("coinc_addr", mem_addr, 32'h400);
        tick();
        check_bit("coinc_req2", mem_req, 1'b1);
        check("coinc_addr2", mem_addr, 32'h400);
        tick();
        check("coinc_inst_pc", inst_pc, 32'h400);

        // Reset mid-wait with stray acks during and after reset.
        wait_n = 3;
        repeat (5) tick();
        check_bit("mid_wait_req", mem_req, 1'b1);
        reset    = 1'b1;
        junk_ack = 1'b1;
        tick();
        check_bit("rst_req_a", mem_req, 1'b0);
        check_bit("rst_valid_a", inst_valid, 1'b0);
        tick();
        check_bit("rst_req_b", mem_req, 1'b0);
        check_bit("rst_valid_b", inst_valid, 1'b0);
        reset = 1'b0;
        tick();
        junk_ack = 1'b0;
        check_bit("post_rst_req", mem_req, 1'b1);
        check("post_rst_addr", mem_addr, RESET_PC);
        guard = 0;
        while (!inst_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("post_rst_inst_pc", inst_pc, 32'h0);
        check("post_rst_inst", inst, 32'h0);

        // fetch_pc wrap.
        wait_n = 0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        clear_log();
        repeat (14) tick();
        check_pop(0, 32'hFFFF_FFF8, 32'h3FFF_FFFE);
        check_pop(1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        check_pop(2, 32'h0000_0000, 32'h0000_0000);
        check_pop(3, 32'h0000_0004, 32'h0000_0001);

        // Randomized traffic against the model.
        rand_waits = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            reset       = ($urandom_range(0, 199) == 0);
            junk_ack    = ($urandom_range(0, 3) == 0);
            tick();
        end
        reset    = 1'b0;
        redirect = 1'b0;
        junk_ack = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
